// File: rtl/moore_seq_detect.sv
// Moore serial pattern detector with a KMP transition table built at elaboration.
// A saturating counter records each entry into the detect state.
module moore_seq_detect #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int SW = $clog2(PAT_W + 1);
    localparam int TW = (PAT_W + 1) * 2 * SW;

    typedef logic [SW-1:0] state_t;

    localparam state_t S0  = '0;
    localparam state_t DET = SW'(PAT_W);

    function automatic int delta(input int k, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic s;
        best = 0;
        for (int l = 1; l <= PAT_W; l++) begin
            ok = (l <= k + 1);
            for (int j = 0; j < PAT_W; j++) begin
                if (ok && (j < l)) begin
                    idx = k + 1 - l + j;
                    if (idx < k) s = PATTERN[PAT_W-1-idx];
                    else         s = b;
                    if (s != PATTERN[PAT_W-1-j]) ok = 1'b0;
                end
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    function automatic int lps();
        int   f;
        logic ok;
        f = 0;
        for (int l = 1; l < PAT_W; l++) begin
            ok = 1'b1;
            for (int j = 0; j < PAT_W; j++) begin
                if (j < l) begin
                    if (PATTERN[PAT_W-1-j] != PATTERN[l-1-j]) ok = 1'b0;
                end
            end
            if (ok) f = l;
        end
        return f;
    endfunction

    // Row PAT_W holds the DET exits: resume from the border or from S0.
    function automatic logic [TW-1:0] build();
        logic [TW-1:0] t;
        int            src;
        t = '0;
        for (int k = 0; k <= PAT_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                if (k == PAT_W) src = OVERLAP ? lps() : 0;
                else            src = k;
                t[(2*k+b)*SW +: SW] = SW'(delta(src, 1'(b)));
            end
        end
        return t;
    endfunction

    localparam logic [TW-1:0] TBL = build();

    state_t state;
    state_t nxt;
    logic   hit;

    always_comb begin
        nxt = TBL[(2*int'(state) + int'(din))*SW +: SW];
        hit = din_valid && (nxt == DET);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S0;
            dout      <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            if (din_valid) begin
                state <= nxt;
                dout  <= (nxt == DET);
            end
            if (cnt_clr) begin
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
            end else if (hit) begin
                if (&match_cnt) cnt_sat   <= 1'b1;
                else            match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_moore_seq_detect.sv
// Directed bench for moore_seq_detect across several parameter sets.
// All instances share stimulus; each is checked only in its own scenarios.
module tb_moore_seq_detect;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic cnt_clr = 1'b0;

    logic       d0, d1, d2, d3, d4, d5;
    logic [7:0] c0, c1, c2, c3, c5;
    logic [1:0] c4;
    logic       s0, s1, s2, s3, s4, s5;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    moore_seq_detect u0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .dout(d0), .match_cnt(c0), .cnt_sat(s0)
    );
    moore_seq_detect #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .dout(d1), .match_cnt(c1), .cnt_sat(s1)
    );
    moore_seq_detect #(.PATTERN(4'b1101)) u2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .dout(d2), .match_cnt(c2), .cnt_sat(s2)
    );
    moore_seq_detect #(.PATTERN(4'b1101), .OVERLAP(1'b0)) u3 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .dout(d3), .match_cnt(c3), .cnt_sat(s3)
    );
    moore_seq_detect #(.CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .dout(d4), .match_cnt(c4), .cnt_sat(s4)
    );
    moore_seq_detect #(.PAT_W(2), .PATTERN(2'b11)) u5 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .dout(d5), .match_cnt(c5), .cnt_sat(s5)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic v, input logic c);
        @(negedge clk);
        din = d;
        din_valid = v;
        cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        cnt_clr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [10:0] alt;
    logic [10:0] e0;
    logic [10:0] e1;
    logic [6:0]  s1101;
    logic [6:0]  e2;
    logic [6:0]  e3;

    initial begin
        alt = 11'b10101010101;
        e0  = 11'b00010101010;
        e1  = 11'b00010001000;
        s1101 = 7'b1101101;
        e2  = 7'b0001001;
        e3  = 7'b0001000;

        #3;
        check("reset_dout", int'(d0), 0);
        check("reset_cnt", int'(c0), 0);
        check("reset_sat", int'(s0), 0);
        @(negedge clk);
        rst = 1'b1;

        // Alternating stream, overlap vs restart
        for (int i = 0; i < 11; i++) begin
            step(alt[10-i], 1'b1, 1'b0);
            check($sformatf("alt_ovl_dout_b%0d", i + 1), int'(d0), int'(e0[10-i]));
            check($sformatf("alt_novl_dout_b%0d", i + 1), int'(d1), int'(e1[10-i]));
        end
        check("alt_ovl_cnt", int'(c0), 4);
        check("alt_novl_cnt", int'(c1), 2);

        // Valid gap in the middle of a match
        do_reset();
        check("rst_clears_cnt", int'(c0), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("gap_dout_%0d", i), int'(d0), 0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("gap_pre_dout", int'(d0), 0);
        step(1'b0, 1'b1, 1'b0);
        check("gap_match_dout", int'(d0), 1);
        check("gap_match_cnt", int'(c0), 1);

        // Asynchronous reset while dout is high
        @(negedge clk);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_dout", int'(d0), 0);
        check("async_rst_cnt", int'(c0), 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-sequence discards the partial match
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        check("partial_rst_dout", int'(d0), 0);
        check("partial_rst_cnt", int'(c0), 0);

        // Pattern 1101, overlap vs restart
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(s1101[6-i], 1'b1, 1'b0);
            check($sformatf("p1101_ovl_dout_b%0d", i + 1), int'(d2), int'(e2[6-i]));
            check($sformatf("p1101_novl_dout_b%0d", i + 1), int'(d3), int'(e3[6-i]));
        end
        check("p1101_ovl_cnt", int'(c2), 2);
        check("p1101_novl_cnt", int'(c3), 1);

        // Pattern 11: DET re-entered directly from DET, then held
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        check("p11_b1_dout", int'(d5), 0);
        step(1'b1, 1'b1, 1'b0);
        check("p11_b2_dout", int'(d5), 1);
        step(1'b1, 1'b1, 1'b0);
        check("p11_b3_dout", int'(d5), 1);
        check("p11_b3_cnt", int'(c5), 2);
        step(1'b0, 1'b0, 1'b0);
        check("p11_hold_dout", int'(d5), 1);
        check("p11_hold_cnt", int'(c5), 2);
        step(1'b0, 1'b1, 1'b0);
        check("p11_exit_dout", int'(d5), 0);

        // Saturation with a 2-bit counter, then clear beating an increment
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("sat_m1_cnt", int'(c4), 1);
        for (int m = 2; m <= 4; m++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            if (m == 3) begin
                check("sat_m3_cnt", int'(c4), 3);
                check("sat_m3_flag", int'(s4), 0);
            end
        end
        check("sat_m4_cnt", int'(c4), 3);
        check("sat_m4_flag", int'(s4), 1);
        check("sat_m4_dout", int'(d4), 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("clr_m5_cnt", int'(c4), 0);
        check("clr_m5_flag", int'(s4), 0);
        check("clr_m5_dout", int'(d4), 1);
        step(1'b1, 1'b1, 1'b0);
        check("post_clr_dout", int'(d4), 0);
        check("post_clr_cnt", int'(c4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_seq_detect.md
MOORE_SEQ_DETECT -- requirements
Module: moore_seq_detect

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1010: target sequence; bit PAT_W-1 is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 allows overlapping matches; 0 restarts the search after each match.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  in  1  the single clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low; low forces the reset state immediately.
REQ-007 din  in  1  serial data bit, sampled on the rising clk edge when din_valid=1.
REQ-008 din_valid  in  1  qualifies din; when low, din is ignored and the FSM holds.
REQ-009 cnt_clr  in  1  synchronous clear of match_cnt and cnt_sat.
REQ-010 dout  out  1  Moore detect flag; high exactly while the FSM is in state DET.
REQ-011 match_cnt  out  CNT_W  number of entries into DET since reset or clear; saturating.
REQ-012 cnt_sat  out  1  sticky flag; high once match_cnt has saturated.

Function
REQ-013 The FSM SHALL have PAT_W+1 states, S0..S(PAT_W-1) plus DET; Sk means the k most recent valid bits equal the first k pattern bits.
REQ-014 The FSM SHALL use a KMP-style transition table derived from PATTERN at elaboration; with din_valid=1, a mismatch in Sk goes to the longest prefix that is also a suffix of the received bits.
REQ-015 With din_valid=1, a matching bit in S(PAT_W-1) SHALL move the FSM to DET on that edge.
REQ-016 dout SHALL depend only on the state register: it rises in the cycle after the edge that samples the final pattern bit (latency 1 clk) and has no combinational path from din.
REQ-017 From DET with din_valid=1 and OVERLAP=1, the next state SHALL be the transition from S(f) on din, where f is the length of the longest proper prefix-suffix of PATTERN.
REQ-018 From DET with din_valid=1 and OVERLAP=0, the next state SHALL be the transition from S0 on din.
REQ-019 A match SHALL make the FSM re-enter DET directly from DET when the overlap transition completes the pattern, for example PATTERN=11 with din=1,1,1; dout then stays high.
REQ-020 With din_valid=0, the FSM state SHALL hold, including DET; dout stays high but match_cnt does not increment again.
REQ-021 match_cnt SHALL increment by 1 on every clk edge whose next state is DET and din_valid=1, including DET->DET.
REQ-022 At value 2^CNT_W-1, match_cnt SHALL hold and cnt_sat SHALL go high on the edge of the attempted increment.
REQ-023 If cnt_clr=1 and an increment occur on the same edge, cnt_clr SHALL win: match_cnt=0 and cnt_sat=0.
REQ-024 cnt_clr SHALL NOT affect the FSM state or dout.

Reset
REQ-025 With rst=0, the FSM SHALL go to S0 asynchronously, and dout=0, match_cnt=0 and cnt_sat=0 SHALL hold until rst returns high.
REQ-026 Reset asserted mid-sequence SHALL discard any partial match; no bits received before reset count toward a later match.
REQ-027 The first bit sampled after rst deasserts SHALL be the first edge with rst=1 and din_valid=1.

Verification
REQ-028 Defaults, din_valid=1, din=1,0,1,0,1,0,1,0,1,0,1, one bit per cycle -> dout high for 1 cycle after bits 4, 6, 8 and 10; match_cnt=4.
REQ-029 Same stream with OVERLAP=0 -> dout high after bits 4 and 8 only; match_cnt=2.
REQ-030 Defaults, din=1,0, then din_valid=0 for 3 cycles with din=1, then din=1,0 -> dout high after the final 0; match_cnt=1; dout does not change during the gap.
REQ-031 Defaults, din=1,0,1, then rst low for 1 cycle, then din=0 -> dout stays 0; match_cnt=0.
REQ-032 PATTERN=4'b1101, din=1,1,0,1,1,0,1 -> OVERLAP=1: 2 matches (after bits 4 and 7); OVERLAP=0: 1 match.
REQ-033 CNT_W=2, 5 matches -> match_cnt=3 and cnt_sat=1 after the 4th match; cnt_clr together with the 5th match -> match_cnt=0 and cnt_sat=0 while dout=1.
